// File: rtl/vga_vram_scanner.sv
// vga_vram_scanner: VGA raster timing plus 1bpp RGB VRAM fetch, upscaled by SCALE, with tear-free image select.
module vga_vram_scanner #(
  parameter int CLK_DIV   = 4,
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int SCALE     = 5,
  parameter int IMG_W     = 128,
  parameter int IMG_H     = 96
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  image_sel,
  input  logic        vram_red,
  input  logic        vram_green,
  input  logic        vram_blue,
  output logic [13:0] vram_addr,
  output logic [1:0]  vram_sel,
  output logic [3:0]  vga_red,
  output logic [3:0]  vga_green,
  output logic [3:0]  vga_blue,
  output logic        vga_hsync,
  output logic        vga_vsync,
  output logic        frame_start
);
  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int DW = $clog2(CLK_DIV);
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int SW = SCALE > 1 ? $clog2(SCALE) : 1;
  localparam int XW = $clog2(IMG_W);
  localparam int YW = IMG_H > 1 ? $clog2(IMG_H) : 1;
  localparam logic [DW-1:0] DIV_LAST   = DW'(CLK_DIV - 1);
  localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_VIS      = HW'(H_VISIBLE);
  localparam logic [HW-1:0] H_VIS_LAST = HW'(H_VISIBLE - 1);
  localparam logic [HW-1:0] HS_BEG     = HW'(H_VISIBLE + H_FRONT);
  localparam logic [HW-1:0] HS_END     = HW'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_VIS      = VW'(V_VISIBLE);
  localparam logic [VW-1:0] V_VIS_LAST = VW'(V_VISIBLE - 1);
  localparam logic [VW-1:0] VS_BEG     = VW'(V_VISIBLE + V_FRONT);
  localparam logic [VW-1:0] VS_END     = VW'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [SW-1:0] SUB_LAST   = SW'(SCALE - 1);
  logic [DW-1:0] div;
  logic [HW-1:0] h;
  logic [VW-1:0] v;
  logic [SW-1:0] hsub, vsub;
  logic [XW-1:0] hpix;
  logic [YW-1:0] vrow;
  logic          active_d, hs_d, vs_d;
  logic          pix_tick, h_wrap, v_wrap, visible, h_clr, v_clr, sample_sel;
  logic [SW-1:0] hsub_n, vsub_n;
  logic [XW-1:0] hpix_n;
  logic [YW-1:0] vrow_n;
  always_comb begin
    pix_tick    = div == DIV_LAST;
    h_wrap      = h == H_LAST;
    v_wrap      = v == V_LAST;
    visible     = h < H_VIS && v < V_VIS;
    frame_start = pix_tick && h == '0 && v == '0;
    sample_sel  = h == '0 && v == V_VIS;
    // scale counters describe the pixel the raster counters move to next
    h_clr  = h_wrap || h >= H_VIS_LAST;
    hsub_n = h_clr || hsub == SUB_LAST ? '0 : hsub + 1'b1;
    hpix_n = h_clr ? '0 : hsub == SUB_LAST ? hpix + 1'b1 : hpix;
    v_clr  = v_wrap || v >= V_VIS_LAST;
    vsub_n = !h_wrap ? vsub : v_clr || vsub == SUB_LAST ? '0 : vsub + 1'b1;
    vrow_n = !h_wrap ? vrow : v_clr ? '0 : vsub == SUB_LAST ? vrow + 1'b1 : vrow;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      div       <= '0;
      h         <= '0;
      v         <= '0;
      hsub      <= '0;
      hpix      <= '0;
      vsub      <= '0;
      vrow      <= '0;
      vram_addr <= '0;
      vram_sel  <= '0;
      active_d  <= 1'b0;
      hs_d      <= 1'b1;
      vs_d      <= 1'b1;
      vga_red   <= '0;
      vga_green <= '0;
      vga_blue  <= '0;
      vga_hsync <= 1'b1;
      vga_vsync <= 1'b1;
    end else begin
      div <= pix_tick ? '0 : div + 1'b1;
      if (pix_tick) begin
        h         <= h_wrap ? '0 : h + 1'b1;
        v         <= !h_wrap ? v : v_wrap ? '0 : v + 1'b1;
        hsub      <= hsub_n;
        hpix      <= hpix_n;
        vsub      <= vsub_n;
        vrow      <= vrow_n;
        vram_addr <= visible ? 14'({vrow, hpix}) : '0;
        vram_sel  <= sample_sel ? image_sel : vram_sel;
        active_d  <= visible;
        hs_d      <= !(h >= HS_BEG && h < HS_END);
        vs_d      <= !(v >= VS_BEG && v < VS_END);
        // BRAM data for the address issued last tick is settled by now
        vga_red   <= {4{vram_red & active_d}};
        vga_green <= {4{vram_green & active_d}};
        vga_blue  <= {4{vram_blue & active_d}};
        vga_hsync <= hs_d;
        vga_vsync <= vs_d;
      end
    end
  end
endmodule

// File: tb/tb_vga_vram_scanner.sv
// tb_vga_vram_scanner: scoreboard bench on a shrunken raster, reference model computed per pixel index.
module tb_vga_vram_scanner;
  localparam int DIV = 3;
  localparam int HV = 40, HF = 4, HSY = 6, HB = 6, HT = HV + HF + HSY + HB;
  localparam int VV = 30, VF = 2, VSY = 2, VB = 3, VT = VV + VF + VSY + VB;
  localparam int SC = 5, IW = 8, IH = 6;
  localparam int FT = HT * VT;
  typedef struct packed {
    logic [13:0] addr;
    logic [1:0]  sel;
    logic [3:0]  r, g, b;
    logic        hs, vs, fs;
  } exp_t;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  image_sel = 2'd0;
  logic        vram_red = 1'b0, vram_green = 1'b0, vram_blue = 1'b0;
  logic [13:0] vram_addr;
  logic [1:0]  vram_sel;
  logic [3:0]  vga_red, vga_green, vga_blue;
  logic        vga_hsync, vga_vsync, frame_start;
  logic        gmem [16384];
  logic        bmem [16384];
  logic        tie = 1'b0;
  logic        started = 1'b0;
  int          total = 0, bad = 0;
  int          cyc = 0, n, k, hh, vv;
  logic        vis;
  logic [13:0] a;
  exp_t        m, e;
  exp_t        q [$];

  vga_vram_scanner #(
    .CLK_DIV(DIV), .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HSY), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VSY), .V_BACK(VB),
    .SCALE(SC), .IMG_W(IW), .IMG_H(IH)
  ) dut (
    .clk(clk), .reset(reset), .image_sel(image_sel),
    .vram_red(vram_red), .vram_green(vram_green), .vram_blue(vram_blue),
    .vram_addr(vram_addr), .vram_sel(vram_sel),
    .vga_red(vga_red), .vga_green(vga_green), .vga_blue(vga_blue),
    .vga_hsync(vga_hsync), .vga_vsync(vga_vsync), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  function automatic logic [13:0] addr_of(input int p);
    int kk = p % FT;
    int x = kk % HT;
    int y = kk / HT;
    return (x < HV && y < VV) ? 14'((y / SC) * IW + x / SC) : 14'd0;
  endfunction

  task automatic chk(input string nm, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      if (bad <= 20) $display("FAIL %s t=%0t got=%0h exp=%0h", nm, $time, got, exp);
    end
  endtask

  // BRAM planes: one clk read latency
  initial forever begin
    @(posedge clk);
    vram_red   <= tie | vram_addr[0];
    vram_green <= gmem[vram_addr];
    vram_blue  <= bmem[vram_addr];
  end

  // reference model: pushes the expected output vector for every clk
  initial forever begin
    @(posedge clk);
    if (reset) begin
      cyc = 0;
      m = '0;
      m.hs = 1'b1;
      m.vs = 1'b1;
      started = 1'b1;
    end else if (started) begin
      cyc++;
      if (cyc % DIV == 0) begin
        n = cyc / DIV - 1;
        if (n > 0) begin
          k = (n - 1) % FT;
          hh = k % HT;
          vv = k / HT;
          vis = hh < HV && vv < VV;
          a = addr_of(n - 1);
          m.r = {4{vis & (tie | a[0])}};
          m.g = {4{vis & gmem[a]}};
          m.b = {4{vis & bmem[a]}};
          m.hs = !(hh >= HV + HF && hh < HV + HF + HSY);
          m.vs = !(vv >= VV + VF && vv < VV + VF + VSY);
        end
        m.addr = addr_of(n);
        if (n % FT == VV * HT) m.sel = image_sel;
      end
      m.fs = (cyc % DIV == DIV - 1) && ((cyc / DIV) % FT == 0);
    end
    if (started) q.push_back(m);
  end

  // monitor: compares every pushed expectation against the pins
  initial forever begin
    @(negedge clk);
    while (q.size() > 0) begin
      e = q.pop_front();
      chk("addr", int'(vram_addr), int'(e.addr));
      chk("sel", int'(vram_sel), int'(e.sel));
      chk("red", int'(vga_red), int'(e.r));
      chk("green", int'(vga_green), int'(e.g));
      chk("blue", int'(vga_blue), int'(e.b));
      chk("hsync", int'(vga_hsync), int'(e.hs));
      chk("vsync", int'(vga_vsync), int'(e.vs));
      chk("frame_start", int'(frame_start), int'(e.fs));
    end
  end

  // returns at the negedge of the pix_tick cycle for pixel (x,y)
  task automatic wait_pix(input int x, input int y);
    int w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!(cyc % DIV == DIV - 1 && (cyc / DIV) % FT == y * HT + x) && w < 3 * FT * DIV);
    if (w >= 3 * FT * DIV) begin
      total++;
      bad++;
      $display("FAIL wait_pix x=%0d y=%0d got=timeout exp=reached", x, y);
    end
  endtask

  initial begin
    int c;
    for (int i = 0; i < 16384; i++) begin
      gmem[i] = 1'($urandom);
      bmem[i] = 1'($urandom);
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    wait_pix(0, 10);
    image_sel = 2'd2;
    wait_pix(0, VV);
    chk("sel_hold", int'(vram_sel), 0);
    @(negedge clk);
    chk("sel_swap", int'(vram_sel), 2);
    wait_pix(0, 5);
    image_sel = 2'd1;
    wait_pix(0, 15);
    image_sel = 2'd2;
    wait_pix(0, VV);
    chk("sel_pulse", int'(vram_sel), 2);
    image_sel = 2'd3;
    @(negedge clk);
    chk("sel_same_cycle", int'(vram_sel), 3);
    wait_pix(0, VV + 1);
    tie = 1'b1;
    wait_pix(0, VV + 1);
    tie = 1'b0;
    for (int i = 0; i < 20; i++) begin
      repeat ($urandom_range(1, 600)) @(negedge clk);
      image_sel = 2'($urandom);
    end
    wait_pix(30, 20);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!frame_start && c < DIV + 2);
    chk("first_tick_fs", c, DIV - 1);
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!frame_start && c < FT * DIV + 10);
    chk("frame_period", c, FT * DIV);
    repeat (50) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
